ifetch: RTL and testbench

Instruction fetch stage placed directly upstream of the decode/execute path and in front of `imem`. Holds the architectural fetch PC, drives the instruction memory address every cycle, and buffers fetched instructions with their PCs in a small FIFO. Presents them to the downstream stage over a valid/ready handshake, and accepts redirects (branch/jump/trap targets) that flush the buffer and restart fetch.

---
 rtl/ifetch_if.sv | 59 +++++
 rtl/ifetch.sv | 125 ++++++++++++
 tb/tb_ifetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// ifetch_if: bundle of the fetch-stage bus signals.
//
// Groups the instruction-memory port, the redirect input and the downstream
// output handshake of the ifetch stage.
//   master : the ifetch stage itself
//   slave  : the environment (imem, redirect source, decode stage)
//
// Handshake semantics (out_* channel): an entry transfers on every rising
// clk edge where out_valid && out_ready are both 1. out_valid depends only
// on stage state, never on out_ready. While out_valid=1 and out_ready=0 the
// head (out_inst/out_pc/out_misalign) holds steady. The only exception is
// redirect_valid, which flushes the buffer at the edge whether or not the
// head was accepted.
//
// Signals:
//   imem_addr      word index into imem (pc[11:2])
//   imem_word      access size, constant 2 (32-bit)
//   imem_data      combinational imem read data, instruction in [31:0]
//   redirect_valid load redirect_pc and flush this cycle
//   redirect_pc    redirect target
//   out_valid      head entry valid
//   out_ready      downstream accepts head entry
//   out_inst       head instruction
//   out_pc         PC of head instruction
//   out_misalign   head entry is a misaligned-target fault
//   dbg_count      debug view of the buffer occupancy
interface ifetch_if;
  logic [9:0]  imem_addr;
  logic [1:0]  imem_word;
  logic [63:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_misalign;
  logic [7:0]  dbg_count;

  modport master (
    output imem_addr, imem_word,
    input  imem_data,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst, out_pc, out_misalign,
    output dbg_count
  );

  modport slave (
    input  imem_addr, imem_word,
    output imem_data,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst, out_pc, out_misalign,
    input  dbg_count
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage.
//
// Holds the fetch PC, addresses imem every cycle with pc[11:2], and buffers
// fetched instructions with their PCs in a DEPTH-entry FIFO that drives the
// downstream valid/ready channel. A redirect flushes the FIFO and restarts
// fetch at the target on the following cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    ifetch_if.master (imem port, redirect, output handshake, debug)
//
// Parameters:
//   RESET_PC  fetch PC loaded on reset
//   DEPTH     FIFO entries (power of two, >= 2)
//
// Build option:
//   IFETCH_MISALIGN_EN  when defined, a redirect target with nonzero [1:0]
//   produces a single fault entry (out_misalign=1) and halts fetch until the
//   next aligned redirect. When undefined, targets are aligned down and
//   out_misalign is tied 0.
module ifetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input logic      clk,
  input logic      reset,
  ifetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]   pc;
  logic [63:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          push;
  logic          pop;
  logic [31:0]   push_inst;
  logic [63:0]   next_pc;
  logic [63:0]   redir_pc;

  // Room is judged on the start-of-cycle count; a same-cycle pop does not
  // free a slot. With DEPTH=2 this still streams one instruction per cycle.
  assign full = (count == CW'(DEPTH));
  assign pop  = (count != '0) && bus.out_ready;

`ifdef IFETCH_MISALIGN_EN
  logic halt;
  logic fault;
  logic fifo_mis [DEPTH];

  // pc can only be misaligned right after a misaligned redirect; that cycle
  // enqueues the fault entry instead of an imem read and then halts.
  assign fault     = (pc[1:0] != 2'b00);
  assign push      = !bus.redirect_valid && !full && !halt;
  assign push_inst = fault ? 32'h0 : bus.imem_data[31:0];
  assign next_pc   = fault ? pc : pc + 64'd4;
  assign redir_pc  = bus.redirect_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_mis[i] <= 1'b0;
    end else if (bus.redirect_valid) begin
      halt <= 1'b0;
    end else if (push) begin
      fifo_mis[wr_ptr] <= fault;
      halt             <= fault;
    end
  end

  assign bus.out_misalign = fifo_mis[rd_ptr];
`else
  assign push      = !bus.redirect_valid && !full;
  assign push_inst = bus.imem_data[31:0];
  assign next_pc   = pc + 64'd4;
  assign redir_pc  = {bus.redirect_pc[63:2], 2'b00};

  assign bus.out_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // A same-cycle handshake still completes downstream; the buffer is
      // cleared regardless.
      pc     <= redir_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= pc;
        fifo_inst[wr_ptr] <= push_inst;
        wr_ptr            <= wr_ptr + 1'b1;
        pc                <= next_pc;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign bus.imem_addr = pc[11:2];
  assign bus.imem_word = 2'd2;
  assign bus.out_valid = (count != '0);
  assign bus.out_inst  = fifo_inst[rd_ptr];
  assign bus.out_pc    = fifo_pc[rd_ptr];
  assign bus.dbg_count = 8'(count);

  logic unused_bits;
  assign unused_bits = ^{bus.imem_data[63:32], bus.redirect_pc[1:0]};
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch.
//
// imem is modelled as word k = 32'h1000 + k with random upper 32 bits. The
// reference model is a queue of expected entries plus an expected fetch PC;
// every cycle the DUT head, imem address and occupancy are compared to it.
module tb_ifetch;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_if bus ();

  ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] imem_hi;
  assign bus.imem_data = {imem_hi, 32'h1000 + {22'd0, bus.imem_addr}};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // entry layout: {pc[63:0], inst[31:0], misalign}
  logic [96:0] exp_q[$];
  logic [63:0] m_pc;
  bit          m_halt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model over one clock edge with the given inputs.
  function automatic void model_update(input logic rn, input logic rv,
                                       input logic [63:0] rpc, input logic rdy);
    int n;
    n = exp_q.size();
    if (!rn) begin
      exp_q.delete();
      m_pc   = RESET_PC;
      m_halt = 0;
    end else if (rv) begin
      exp_q.delete();
`ifdef IFETCH_MISALIGN_EN
      m_pc = rpc;
`else
      m_pc = rpc & ~64'h3;
`endif
      m_halt = 0;
    end else begin
      if (n != 0 && rdy) void'(exp_q.pop_front());
      if (n < DEPTH && !m_halt) begin
        if (m_pc[1:0] != 2'b00) begin
          exp_q.push_back({m_pc, 32'h0, 1'b1});
          m_halt = 1;
        end else begin
          exp_q.push_back({m_pc, 32'h1000 + {22'd0, m_pc[11:2]}, 1'b0});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endfunction

  // ---------------- driver ----------------
  // Check the current state at negedge, drive the next inputs, then let the
  // model follow the DUT across the posedge.
  task automatic step(input logic rn, input logic rv, input logic [63:0] rpc, input logic rdy);
    logic [96:0] head;
    @(negedge clk);
    check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_pc", bus.out_pc, head[96:33]);
      check("out_inst", 64'(bus.out_inst), 64'(head[32:1]));
      check("out_misalign", 64'(bus.out_misalign), 64'(head[0]));
    end
    check("imem_addr", 64'(bus.imem_addr), 64'(m_pc[11:2]));
    check("imem_word", 64'(bus.imem_word), 64'd2);
    check("count", 64'(bus.dbg_count), 64'(exp_q.size()));

    reset              = rn;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    imem_hi            = $urandom;

    // Reset acts without a clock edge.
    if (!rn) begin
      #1;
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_imem_addr", 64'(bus.imem_addr), 64'(RESET_PC[11:2]));
      check("rst_out_pc", bus.out_pc, 64'd0);
      check("rst_out_inst", 64'(bus.out_inst), 64'd0);
      check("rst_out_misalign", 64'(bus.out_misalign), 64'd0);
      check("rst_count", 64'(bus.dbg_count), 64'd0);
    end

    @(posedge clk);
    model_update(rn, rv, rpc, rdy);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 64'h0, rdy);
  endtask

  task automatic redirect(input logic [63:0] target, input logic rdy);
    step(1'b1, 1'b1, target, rdy);
  endtask

  // ---------------- stimulus ----------------
  logic        r_rn;
  logic        r_rv;
  logic        r_rdy;
  logic [63:0] r_pc;

  initial begin
    m_pc               = RESET_PC;
    m_halt             = 0;
    imem_hi            = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.out_ready      = 1'b0;
    reset              = 1'b1;
    #1 reset           = 1'b0;

    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);

    // streaming from release
    run(8, 1'b1);

    // back-pressure from the first valid, then resume
    step(1'b0, 1'b0, 64'h0, 1'b0);
    run(1, 1'b0);
    run(5, 1'b0);
    run(6, 1'b1);

    // redirect with simultaneous pop
    step(1'b0, 1'b0, 64'h0, 1'b1);
    run(3, 1'b1);
    redirect(64'h40, 1'b1);
    run(5, 1'b1);

    // PC wrap-around
    redirect(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    run(4, 1'b1);
    redirect(64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    run(4, 1'b0);
    run(4, 1'b1);

    // misaligned target, then aligned restart
    redirect(64'h42, 1'b1);
    run(4, 1'b1);
    redirect(64'h80, 1'b1);
    run(4, 1'b1);
    redirect(64'h43, 1'b0);
    run(3, 1'b0);
    redirect(64'h41, 1'b1);
    run(3, 1'b1);
    redirect(64'h100, 1'b1);
    run(3, 1'b1);

    // reset while full
    run(4, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    run(4, 1'b1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      r_rn  = ($urandom_range(0, 59) != 0);
      r_rv  = ($urandom_range(0, 7) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       r_pc = {$urandom, $urandom};
        1:       r_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        2:       r_pc = 64'($urandom_range(0, 255));
        default: r_pc = {32'h0, $urandom} & ~64'h3;
      endcase
      step(r_rn, r_rv, r_pc, r_rdy);
    end
    run(3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
